// File: rtl/muldiv_seq.sv
// Iterative RV32M-style multiply/divide unit: one shift-add or restoring-divide
// step per cycle, valid/ready operand and result handshakes, ALU-style flags.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] bus_a,
    input  logic [XLEN-1:0] bus_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_zero,
    output logic            out_neg,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    state_t            r_state;
    op_t               r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_rneg;
    logic              r_spec;
    logic [XLEN-1:0]   r_data;
    logic              r_zero;
    logic              r_neg;

    op_t               w_op;
    logic              w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_rneg;
    logic              w_dz, w_ovf;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res;
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_nhi, w_nlo;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_res;

    // Operand decode at acceptance: magnitudes, result sign, special cases
    always_comb begin
        w_op       = op_t'(op);
        w_is_div   = op[2];
        w_a_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                     (w_op == OP_DIV)  || (w_op == OP_REM);
        w_b_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_sa       = w_a_signed & bus_a[XLEN-1];
        w_sb       = w_b_signed & bus_b[XLEN-1];
        w_mag_a    = w_sa ? (~bus_a + 1'b1) : bus_a;
        w_mag_b    = w_sb ? (~bus_b + 1'b1) : bus_b;
        w_rneg     = 1'b0;
        if (!w_is_div)           w_rneg = w_sa ^ w_sb;
        else if (w_op == OP_DIV) w_rneg = w_sa ^ w_sb;
        else if (w_op == OP_REM) w_rneg = w_sa;
        w_dz       = w_is_div && (bus_b == '0);
        w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                     (bus_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus_b == '1);
        if (w_dz)  w_spec_res = op[1] ? bus_a : '1;
        else       w_spec_res = op[1] ? '0 : bus_a;
    end

    // One datapath step plus final sign correction and result select
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        w_ge    = ~w_diff[XLEN];
        if (r_op[2]) begin
            w_nhi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_nhi = w_sum[XLEN:1];
            w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod   = {w_nhi, w_nlo};
        w_prod_s = r_rneg ? (~w_prod + 1'b1) : w_prod;
        case (r_op)
            OP_MUL:           w_res = w_prod_s[XLEN-1:0];
            OP_DIV, OP_DIVU:  w_res = r_rneg ? (~w_nlo + 1'b1) : w_nlo;
            OP_REM, OP_REMU:  w_res = r_rneg ? (~w_nhi + 1'b1) : w_nhi;
            default:          w_res = w_prod_s[2*XLEN-1:XLEN];
        endcase
        if (r_spec) w_res = r_hi;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_MUL;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rneg  <= 1'b0;
            r_spec  <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op    <= w_op;
                    r_cnt   <= '0;
                    r_a     <= w_mag_a;
                    r_b     <= w_mag_b;
                    r_rneg  <= w_rneg;
                    r_spec  <= w_dz | w_ovf;
                    r_hi    <= (w_dz | w_ovf) ? w_spec_res : '0;
                    r_lo    <= w_is_div ? w_mag_a : w_mag_b;
                    r_state <= S_CALC;
                end
                // Special cases park their result in r_hi and spend exactly one
                // CALC cycle, so out_valid appears one edge after acceptance.
                S_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    if (r_spec || (r_cnt == CNT_W'(XLEN-1))) begin
                        r_data  <= w_res;
                        r_zero  <= (w_res == '0);
                        r_neg   <= w_res[XLEN-1];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_data;
    assign out_zero  = r_zero;
    assign out_neg   = r_neg;

endmodule
